// File: rtl/sfp_event_pkg.sv
`default_nettype none
// ============================================================================
// Module : sfp_event_pkg
// Brief  : Shared event-code constants and seconds-sequencer states.
// Rev    : 1.0
// ============================================================================
package sfp_event_pkg;

    localparam logic [7:0] c_evt_sec0    = 8'h70;
    localparam logic [7:0] c_evt_sec1    = 8'h71;
    localparam logic [7:0] c_evt_hb      = 8'h7A;
    localparam logic [7:0] c_evt_presc   = 8'h7B;
    localparam logic [7:0] c_evt_rsv7c   = 8'h7C;
    localparam logic [7:0] c_evt_sec_rst = 8'h7D;
    localparam logic [7:0] c_evt_k285    = 8'hBC;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_SHIFT = 2'd1,
        SEQ_LATCH = 2'd2
    } seq_state_e;

    // Codes owned by the link itself; users may not inject them.
    function automatic logic is_reserved_code(input logic [7:0] code);
        return (code == 8'h00) || (code == c_evt_sec0) || (code == c_evt_sec1) ||
               ((code >= c_evt_hb) && (code <= c_evt_sec_rst)) || (code == c_evt_k285);
    endfunction

endpackage : sfp_event_pkg
`default_nettype wire

// File: rtl/sfp_seconds_shifter.sv
`default_nettype none
// ============================================================================
// Module : sfp_seconds_shifter
// Brief  : Serialises a latched seconds value MSB first, then a reset event.
// Rev    : 1.0
// ============================================================================
module sfp_seconds_shifter
    import sfp_event_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        pps_i,
    input  logic [31:0] seconds_i,
    output logic        active_o,
    output logic [7:0]  code_o,
    output logic        pps_err_o
);

    seq_state_e  state_q, state_d;
    logic [31:0] sec_q, sec_d;
    logic [4:0]  idx_q, idx_d;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= SEQ_IDLE;
            sec_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        idx_d     = idx_q;
        active_o  = 1'b0;
        code_o    = c_evt_k285;
        pps_err_o = pps_i && (state_q != SEQ_IDLE);
        case (state_q)
            SEQ_IDLE: begin
                if (pps_i && enable_i) begin
                    state_d = SEQ_SHIFT;
                    sec_d   = seconds_i;
                    idx_d   = 5'd31;
                end
            end
            SEQ_SHIFT: begin
                active_o = 1'b1;
                code_o   = sec_q[idx_q] ? c_evt_sec1 : c_evt_sec0;
                idx_d    = idx_q - 5'd1;
                if (idx_q == 5'd0) begin
                    state_d = SEQ_LATCH;
                end
            end
            SEQ_LATCH: begin
                active_o = 1'b1;
                code_o   = c_evt_sec_rst;
                state_d  = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
        if (!enable_i) begin
            state_d = SEQ_IDLE;
        end
    end

endmodule : sfp_seconds_shifter
`default_nettype wire

// File: rtl/sfp_event_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : sfp_event_tx_sched
// Brief  : Per-cycle event slot scheduler: seconds, heartbeat, prescaler, user FIFO.
// Rev    : 1.0
// ============================================================================
module sfp_event_tx_sched
    import sfp_event_pkg::*;
#(
    parameter int unsigned HB_PERIOD  = 12500,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        event_valid_i,
    input  logic [7:0]  event_code_i,
    output logic        event_ready_o,
    input  logic        presc_reset_i,
    input  logic        pps_i,
    input  logic [31:0] seconds_i,
    input  logic [7:0]  dbus_i,
    output logic [15:0] txdata_o,
    output logic [1:0]  txcharisk_o,
    output logic        err_o,
    input  logic        err_clr_i
);

    localparam int unsigned         c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]    c_ptr_one = {{c_ptr_w{1'b0}}, 1'b1};

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [c_ptr_w:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]      hb_cnt_q;
    logic             hb_pend_q, presc_pend_q, err_q;
    logic [7:0]       dbus_q, evt_q;
    logic             k_q;

    logic             w_empty, w_full, w_accept, w_bad, w_push, w_pop;
    logic             w_hb_wrap, w_emit_hb, w_emit_presc;
    logic             w_seq_active, w_pps_err, w_err_set;
    logic [7:0]       w_seq_code, w_sel_code;
    logic             w_sel_k;

    sfp_seconds_shifter u_shifter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .enable_i  (enable_i),
        .pps_i     (pps_i),
        .seconds_i (seconds_i),
        .active_o  (w_seq_active),
        .code_o    (w_seq_code),
        .pps_err_o (w_pps_err)
    );

    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                      (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);
    // Gated by reset so the handshake reads 0 throughout reset, not just after it.
    assign event_ready_o = reset_n_i && enable_i && !w_full;
    assign w_accept  = event_valid_i && event_ready_o;
    assign w_bad     = is_reserved_code(event_code_i);
    assign w_push    = w_accept && !w_bad;
    assign w_hb_wrap = (hb_cnt_q == 32'(HB_PERIOD - 1));
    assign w_err_set = (w_accept && w_bad) || w_pps_err;

    always_comb begin
        w_sel_code   = c_evt_k285;
        w_sel_k      = 1'b1;
        w_pop        = 1'b0;
        w_emit_hb    = 1'b0;
        w_emit_presc = 1'b0;
        if (enable_i) begin
            if (w_seq_active) begin
                w_sel_code = w_seq_code;
                w_sel_k    = 1'b0;
            end else if (hb_pend_q) begin
                w_sel_code = c_evt_hb;
                w_sel_k    = 1'b0;
                w_emit_hb  = 1'b1;
            end else if (presc_pend_q) begin
                w_sel_code   = c_evt_presc;
                w_sel_k      = 1'b0;
                w_emit_presc = 1'b1;
            end else if (!w_empty) begin
                w_sel_code = mem_q[rd_ptr_q[c_ptr_w-1:0]];
                w_sel_k    = 1'b0;
                w_pop      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_ptr_w-1:0]] <= event_code_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            hb_cnt_q     <= '0;
            hb_pend_q    <= 1'b0;
            presc_pend_q <= 1'b0;
            err_q        <= 1'b0;
            dbus_q       <= '0;
            evt_q        <= c_evt_k285;
            k_q          <= 1'b1;
        end else begin
            dbus_q <= dbus_i;
            evt_q  <= w_sel_code;
            k_q    <= w_sel_k;
            err_q  <= w_err_set || (err_q && !err_clr_i);
            if (!enable_i) begin
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                hb_cnt_q     <= '0;
                hb_pend_q    <= 1'b0;
                presc_pend_q <= 1'b0;
            end else begin
                hb_cnt_q     <= w_hb_wrap ? 32'd0 : hb_cnt_q + 32'd1;
                hb_pend_q    <= (hb_pend_q && !w_emit_hb) || w_hb_wrap;
                presc_pend_q <= (presc_pend_q && !w_emit_presc) || presc_reset_i;
                if (w_push) begin
                    wr_ptr_q <= wr_ptr_q + c_ptr_one;
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + c_ptr_one;
                end
            end
        end
    end

    assign txdata_o    = {dbus_q, evt_q};
    assign txcharisk_o = {1'b0, k_q};
    assign err_o       = err_q;

endmodule : sfp_event_tx_sched
`default_nettype wire

// File: tb/tb_sfp_event_tx_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_sfp_event_tx_sched
// Brief  : Self-checking bench with a queue-based slot model and directed cases.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sfp_event_tx_sched;

    localparam int HB    = 64;
    localparam int DEPTH = 16;

    logic        clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic        ev_valid = 1'b0, presc = 1'b0, pps = 1'b0, err_clr = 1'b0;
    logic [7:0]  ev_code = '0, dbus = '0;
    logic [31:0] seconds = '0;
    logic        ev_ready, err;
    logic [15:0] txdata;
    logic [1:0]  txk;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sfp_event_tx_sched #(.HB_PERIOD(HB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .enable_i      (enable),
        .event_valid_i (ev_valid),
        .event_code_i  (ev_code),
        .event_ready_o (ev_ready),
        .presc_reset_i (presc),
        .pps_i         (pps),
        .seconds_i     (seconds),
        .dbus_i        (dbus),
        .txdata_o      (txdata),
        .txcharisk_o   (txk),
        .err_o         (err),
        .err_clr_i     (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reserved(input logic [7:0] c);
        return (c == 8'h00) || (c == 8'h70) || (c == 8'h71) ||
               (c >= 8'h7A && c <= 8'h7D) || (c == 8'hBC);
    endfunction

    // Model: planned slots held as queues, outputs appear one cycle after selection.
    byte unsigned m_fifo[$];
    byte unsigned m_seq[$];
    int           m_cnt = 0;
    bit           m_hbp = 0, m_presc = 0, m_err = 0, m_k = 1;
    logic [7:0]   m_evt = 8'hBC, m_dbus = 8'h00;

    always @(posedge clk) begin : model
        bit         rdy, acc, pps_err, wrap, hb_out, pr_out, sk;
        logic [7:0] sel;
        if (!reset_n) begin
            m_fifo.delete(); m_seq.delete();
            m_cnt = 0; m_hbp = 0; m_presc = 0; m_err = 0;
            m_evt = 8'hBC; m_k = 1; m_dbus = 8'h00;
        end else begin
            rdy     = enable && (m_fifo.size() < DEPTH);
            acc     = ev_valid && rdy;
            pps_err = pps && (m_seq.size() != 0);
            sel = 8'hBC; sk = 1; hb_out = 0; pr_out = 0;
            if (enable) begin
                if (m_seq.size() != 0) begin sel = m_seq.pop_front(); sk = 0; end
                else if (m_hbp)        begin sel = 8'h7A; sk = 0; hb_out = 1; end
                else if (m_presc)      begin sel = 8'h7B; sk = 0; pr_out = 1; end
                else if (m_fifo.size() != 0) begin sel = m_fifo.pop_front(); sk = 0; end
            end
            m_evt  = sel;
            m_k    = sk;
            m_dbus = dbus;
            m_err  = (acc && reserved(ev_code)) || pps_err || (m_err && !err_clr);
            if (!enable) begin
                m_cnt = 0; m_hbp = 0; m_presc = 0;
                m_fifo.delete(); m_seq.delete();
            end else begin
                wrap    = (m_cnt == HB - 1);
                m_cnt   = wrap ? 0 : m_cnt + 1;
                m_hbp   = (m_hbp && !hb_out) || wrap;
                m_presc = (m_presc && !pr_out) || presc;
                if (acc && !reserved(ev_code)) m_fifo.push_back(ev_code);
                if (pps && !pps_err) begin
                    for (int i = 31; i >= 0; i--) m_seq.push_back(seconds[i] ? 8'h71 : 8'h70);
                    m_seq.push_back(8'h7D);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_txdata", txdata, 16'h00BC);
            check("rst_charisk", txk, 2'b01);
            check("rst_ready", ev_ready, 1'b0);
            check("rst_err", err, 1'b0);
        end else begin
            check("txdata", txdata, {m_dbus, m_evt});
            check("txcharisk", txk, {1'b0, m_k});
            check("err", err, m_err);
            check("ready", ev_ready, enable && (m_fifo.size() < DEPTH));
        end
    end

    initial begin
        forever begin
            @(negedge clk); #1;
            dbus = 8'($urandom);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    // After return, the first sequence slot is on the outputs.
    task automatic start_pps(input logic [31:0] sec);
        pps = 1'b1; seconds = sec; tick();
        pps = 1'b0; tick();
    endtask

    function automatic logic [7:0] sec5_slot(input int i);
        if (i < 29) return 8'h70;
        if (i == 29 || i == 31) return 8'h71;
        if (i == 30) return 8'h70;
        return 8'h7D;
    endfunction

    initial begin
        int last, n_hb, acc;
        logic [7:0] exp_code;

        repeat (3) tick();
        enable = 1'b1;
        #1;
        check("lit_rst_txdata", txdata, 16'h00BC);
        check("lit_rst_charisk", txk, 2'b01);
        check("lit_rst_ready", ev_ready, 1'b0);
        check("lit_rst_err", err, 1'b0);
        reset_n = 1'b1;

        // Heartbeat on an idle link
        last = -1; n_hb = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (txdata[7:0] == 8'h7A) begin
                if (last >= 0) check("hb_gap", 32'(c - last), 32'd64);
                check("hb_charisk", txk, 2'b00);
                last = c; n_hb++;
            end else begin
                check("hb_idle", {txk, txdata[7:0]}, {2'b01, 8'hBC});
            end
        end
        check("hb_seen3", 32'(n_hb >= 3), 32'd1);

        // Seconds sequence for value 5
        start_pps(32'h0000_0005);
        for (int i = 0; i < 33; i++) begin
            check("sec5_code", txdata[7:0], sec5_slot(i));
            check("sec5_charisk", txk, 2'b00);
            tick();
        end

        // Collision: pps with prescaler reset and two user events
        enable = 1'b0; tick(); enable = 1'b1;
        ev_valid = 1'b1; ev_code = 8'h10; presc = 1'b1; pps = 1'b1; seconds = 32'h5; tick();
        ev_code = 8'h11; presc = 1'b0; pps = 1'b0; tick();
        ev_valid = 1'b0;
        for (int i = 0; i < 36; i++) begin
            exp_code = (i < 33) ? sec5_slot(i) : (i == 33) ? 8'h7B : (i == 34) ? 8'h10 : 8'h11;
            check("coll_code", txdata[7:0], exp_code);
            tick();
        end
        check("coll_err", err, 1'b0);

        // FIFO fills during a sequence, then drains in order
        enable = 1'b0; tick(); enable = 1'b1;
        seconds = 32'h5; pps = 1'b1; tick(); pps = 1'b0;
        acc = 0;
        for (int c = 0; c < 25; c++) begin
            ev_valid = 1'b1; ev_code = 8'(32'h20 + acc);
            if (ev_ready) acc++;
            tick();
        end
        ev_valid = 1'b0;
        check("full_accepts", 32'(acc), 32'd16);
        check("full_ready", ev_ready, 1'b0);
        repeat (9) tick();
        for (int k = 0; k < 16; k++) begin
            check("drain_code", txdata[7:0], 8'(32'h20 + k));
            tick();
        end

        // Errors: dropped reserved code, clear, set-wins, pps during sequence
        ev_valid = 1'b1; ev_code = 8'h7C; tick(); ev_valid = 1'b0;
        check("err_drop", err, 1'b1);
        repeat (2) begin
            check("drop_not_sent", 32'(txdata[7:0] == 8'h7C), 32'd0);
            tick();
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("err_cleared", err, 1'b0);
        ev_valid = 1'b1; ev_code = 8'h00; err_clr = 1'b1; tick();
        ev_valid = 1'b0; err_clr = 1'b0;
        check("err_set_wins", err, 1'b1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        start_pps(32'h0000_0005);
        for (int i = 0; i < 33; i++) begin
            check("pps_inj_code", txdata[7:0], sec5_slot(i));
            pps = (i == 10); if (i == 10) seconds = 32'hFFFF_FFFF;
            tick();
        end
        pps = 1'b0;
        check("pps_inj_err", err, 1'b1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("pps_inj_clr", err, 1'b0);

        // Reset in the middle of a sequence
        start_pps(32'h0000_0005);
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_txdata", txdata, 16'h00BC);
        check("midrst_charisk", txk, 2'b01);
        tick(); tick();
        reset_n = 1'b1;
        check("post_rst_slot0", txdata[7:0], 8'hBC);
        tick();
        check("post_rst_slot1", {txk, txdata[7:0]}, {2'b01, 8'hBC});

        // Disable with queued user events
        start_pps(32'h0000_0005);
        for (int k = 0; k < 3; k++) begin
            ev_valid = 1'b1; ev_code = 8'(32'h30 + k); tick();
        end
        ev_valid = 1'b0; enable = 1'b0; tick();
        check("dis_ready", ev_ready, 1'b0);
        repeat (5) begin
            check("dis_idle", {txk, txdata[7:0]}, {2'b01, 8'hBC});
            tick();
        end
        enable = 1'b1;
        repeat (40) begin
            tick();
            check("reen_idle", txdata[7:0], 8'hBC);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sfp_event_tx_sched
`default_nettype wire

// File: doc/sfp_event_tx_sched.md
SFP_EVENT_TX_SCHED -- requirements
Module: sfp_event_tx_sched

Interface
REQ-001 The block SHALL have parameter HB_PERIOD, default 12500, heartbeat interval in clk_i cycles (range 64 to 2^32-1).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, user event FIFO entries (power of 2).
REQ-003 The block SHALL use one clock, clk_i, and a reset, reset_n_i, that is asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk_i  in  1  clock.
- reset_n_i  in  1  async active-low reset.
- enable_i  in  1  transmit enable.
- event_valid_i  in  1  user event request.
- event_code_i  in  8  user event code.
- event_ready_o  out  1  user event accepted when valid&ready.
- presc_reset_i  in  1  single-cycle request for code 0x7B.
- pps_i  in  1  single-cycle seconds strobe.
- seconds_i  in  32  seconds value, sampled on pps_i.
- dbus_i  in  8  distributed bus bits.
- txdata_o  out  16  {dbus byte, event byte}.
- txcharisk_o  out  2  per-byte K flag.
- err_o  out  1  sticky error.
- err_clr_i  in  1  clears err_o.

Function
REQ-005 Exactly one event slot SHALL be emitted every cycle: txdata_o[7:0] is the event byte; txdata_o[15:8] is dbus_i registered one cycle; txcharisk_o[1] is always 0.
REQ-006 Slot priority SHALL be: seconds sequencer > heartbeat 0x7A > prescaler reset 0x7B > user FIFO head > idle.
REQ-007 An idle slot SHALL emit K28.5 (0xBC) with txcharisk_o = 01; every non-idle slot SHALL have txcharisk_o = 00.
REQ-008 User events SHALL enter a FIFO_DEPTH FIFO; event_ready_o SHALL be high when the FIFO is not full and enable_i = 1.
REQ-009 A user event accepted in cycle N into an empty FIFO, with no higher-priority source pending, SHALL appear on txdata_o in cycle N+2.
REQ-010 User codes 0x00, 0x70, 0x71, 0x7A-0x7D and 0xBC SHALL be accepted but dropped, and SHALL set err_o.
REQ-011 The heartbeat counter SHALL count 0 to HB_PERIOD-1 and wrap. At the wrap it SHALL set hb_pending, which is cleared when 0x7A is emitted. A wrap while hb_pending is already set SHALL merge into that pending request, with no error.
REQ-012 presc_reset_i SHALL set presc_pending, which is cleared on emission of 0x7B. Repeated requests while pending SHALL merge.
REQ-013 The seconds sequencer SHALL have states IDLE, SHIFT and LATCH:
- IDLE -> SHIFT on pps_i: latch seconds_i and set bit index to 31.
- SHIFT: emit 0x71 for bit 1 or 0x70 for bit 0, MSB first, decrementing the index; after bit 0, go to LATCH.
- LATCH: emit 0x7D (reset event), then return to IDLE.
REQ-014 The seconds sequence SHALL occupy exactly 33 consecutive slots and SHALL NOT be interrupted. Other sources SHALL remain pending during it.
REQ-015 pps_i received while not in IDLE SHALL be ignored and SHALL set err_o.
REQ-016 Simultaneous pps_i and a pending source SHALL resolve as follows: the first seconds slot appears in the cycle after pps_i; any slot already committed for that cycle completes first.
REQ-017 enable_i = 0 SHALL force idle slots, clear hb_pending, presc_pending and the FIFO, hold the heartbeat counter at 0, and abort the sequencer to IDLE in the next cycle.
REQ-018 err_o SHALL remain set until err_clr_i = 1. If a set condition and err_clr_i occur in the same cycle, set SHALL win.

Reset
REQ-019 While reset_n_i = 0, outputs SHALL be: txdata_o = 0x00BC, txcharisk_o = 01, event_ready_o = 0, err_o = 0.
REQ-020 While reset_n_i = 0, internal state SHALL be: FIFO empty, pending flags cleared, counter = 0, sequencer in IDLE.
REQ-021 Reset assertion mid-sequence SHALL abort the sequence immediately; after release the first slot SHALL be idle.

Structure
REQ-022 Event-code constants (0x70, 0x71, 0x7A-0x7D, 0xBC) and the sequencer state enumeration SHALL reside in shared package sfp_event_pkg, for reuse by sfp_receiver.
REQ-023 The seconds sequencer SHALL be the sub-module sfp_seconds_shifter. The FIFO and priority mux SHALL be inline.

Verification
REQ-024 Seconds sequence: pps_i with seconds_i = 0x0000_0005 -> 29 slots of 0x70, then 0x71, 0x70, 0x71, then 0x7D; 33 slots total, all charisk 00.
REQ-025 Heartbeat: HB_PERIOD = 64, idle link -> 0x7A every 64 cycles, K28.5 with charisk 01 in all other slots.
REQ-026 Collision: push 0x10, 0x11 and presc_reset_i in the same cycle as pps_i -> 33 seconds slots, then 0x7B, then 0x10, then 0x11; err_o stays 0.
REQ-027 FIFO full: hold event_valid_i during a seconds sequence with FIFO_DEPTH = 16 -> event_ready_o low after 16 accepts; all 16 codes emitted in order afterwards.
REQ-028 Errors: push code 0x7C -> dropped and err_o = 1; pps_i at sequence slot 10 -> sequence unaffected; err_clr_i -> err_o = 0.
REQ-029 Reset/enable: assert reset_n_i at sequence slot 5 -> txdata_o = 0x00BC immediately; enable_i = 0 -> idle slots only and FIFO emptied.
